// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequences RV32M multiplies onto an unsigned multiplier with sign fixup, one-entry product cache, watchdog and flush
module mul_seq_ctrl #(
   parameter int WDOG_LIMIT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [4:0]  rd_tag,
   input  logic        flush,
   output logic        mul_start,
   output logic [31:0] mul_rs1,
   output logic [31:0] mul_rs2,
   output logic        mul_signed,
   input  logic [63:0] mul_result,
   input  logic        mul_valid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_tag,
   output logic        rsp_err
);
   localparam int WW = $clog2(WDOG_LIMIT + 1);
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN} state_t;
   state_t state;
   logic [2:0] f3;
   logic neg, cache_vld, a_neg, b_neg, hit, accept, wdog_exp;
   logic [31:0] last_a, last_b, mag_a, mag_b;
   logic [63:0] prod, prod_fix;
   logic [WW-1:0] wdog;
   assign mul_signed = 1'b0;
   // operand magnitudes, cache lookup and sign-corrected product
   always_comb begin
      a_neg = rs1[31] & (funct3 == 3'b001 || funct3 == 3'b010);
      b_neg = rs2[31] & (funct3 == 3'b001);
      mag_a = a_neg ? -rs1 : rs1;
      mag_b = b_neg ? -rs2 : rs2;
      hit = cache_vld && mag_a == last_a && mag_b == last_b;
      accept = state == IDLE && req_valid && !flush;
      wdog_exp = wdog == WW'(WDOG_LIMIT - 1);
      prod_fix = neg ? -prod : prod;
   end
   // control FSM with registered outputs, cache and watchdog
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         req_ready <= 1'b1;
         mul_start <= 1'b0;
         mul_rs1 <= '0;
         mul_rs2 <= '0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_tag <= '0;
         rsp_err <= 1'b0;
         f3 <= '0;
         neg <= 1'b0;
         cache_vld <= 1'b0;
         last_a <= '0;
         last_b <= '0;
         prod <= '0;
         wdog <= '0;
      end else begin
         mul_start <= 1'b0;
         if (state == LAUNCH || state == WAIT || state == DRAIN) wdog <= wdog + 1'b1;
         case (state)
            IDLE: if (accept) begin
               f3 <= funct3;
               rsp_tag <= rd_tag;
               neg <= a_neg ^ b_neg;
               req_ready <= 1'b0;
               if (funct3[2]) begin
                  state <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err <= 1'b1;
                  rsp_data <= '0;
               end else if (hit) begin
                  state <= FIX;
               end else begin
                  state <= LAUNCH;
                  mul_start <= 1'b1;
                  mul_rs1 <= mag_a;
                  mul_rs2 <= mag_b;
                  wdog <= '0;
               end
            end
            LAUNCH: begin
               state <= flush ? DRAIN : WAIT;
               if (flush) cache_vld <= 1'b0;
            end
            WAIT: if (flush) begin
               cache_vld <= 1'b0;
               state <= mul_valid ? IDLE : DRAIN;
               req_ready <= mul_valid;
            end else if (mul_valid) begin
               prod <= mul_result;
               last_a <= mul_rs1;
               last_b <= mul_rs2;
               cache_vld <= 1'b1;
               state <= FIX;
            end else if (wdog_exp) begin
               state <= RESP;
               rsp_valid <= 1'b1;
               rsp_err <= 1'b1;
               rsp_data <= '0;
               cache_vld <= 1'b0;
            end
            FIX: if (flush) begin
               state <= IDLE;
               req_ready <= 1'b1;
            end else begin
               state <= RESP;
               rsp_valid <= 1'b1;
               rsp_err <= 1'b0;
               rsp_data <= (f3 == 3'b000) ? prod_fix[31:0] : prod_fix[63:32];
            end
            RESP: if (flush || rsp_ready) begin
               state <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            DRAIN: if (mul_valid || wdog_exp) begin
               state <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 40, meaning max cycles from LAUNCH to mul_valid before abort.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  op request.
- req_ready  out  1  request accepted when both high.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- rs1, rs2  in  32 each  operands.
- rd_tag  in  5  destination tag.
- flush  in  1  kill in-flight op.
- mul_start  out  1  start pulse to multiplier.
- mul_rs1, mul_rs2  out  32 each  unsigned operand magnitudes to multiplier.
- mul_signed  out  1  tied 0.
- mul_result  in  64  multiplier product.
- mul_valid  in  1  product-valid pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when both high.
- rsp_data  out  32  result.
- rsp_tag  out  5  captured rd_tag.
- rsp_err  out  1  illegal funct3 or watchdog abort.

Function
REQ-003 SHALL implement states IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN; req_ready=1 only in IDLE.
REQ-004 On accept: capture funct3 and rd_tag; a_neg=rs1[31]&(MULH|MULHSU); b_neg=rs2[31]&MULH; mag_a=a_neg?-rs1:rs1; mag_b=b_neg?-rs2:rs2 (32-bit, 0x80000000 maps to itself).
REQ-005 funct3[2]=1: go to RESP next cycle with rsp_err=1, rsp_data=0; cache untouched.
REQ-006 Cache hit (cache_vld, mag_a==last_a, mag_b==last_b): go to FIX using stored product; no mul_start.
REQ-007 Miss: go to LAUNCH; assert mul_start exactly one cycle; go to WAIT.
REQ-008 mul_rs1/mul_rs2 SHALL hold mag_a/mag_b stable from LAUNCH until WAIT exits.
REQ-009 WAIT: on mul_valid=1, capture mul_result, update last_a/last_b/product, set cache_vld, go to FIX.
REQ-010 FIX: P'=(a_neg^b_neg)?-P:P (64-bit two's complement); rsp_data=P'[31:0] for MUL, else P'[63:32]; rsp_err=0; go to RESP.
REQ-011 RESP: rsp_valid=1; rsp_data/tag/err stable until rsp_ready=1, then IDLE next cycle.
REQ-012 Latency: hit rsp_valid 2 cycles after accept; miss rsp_valid 2 cycles after mul_valid sampled.
REQ-013 Watchdog counts from LAUNCH; reaching WDOG_LIMIT in WAIT: RESP with rsp_err=1, rsp_data=0, cache_vld=0.
REQ-014 flush in LAUNCH or WAIT: go to DRAIN, no response; DRAIN exits to IDLE on mul_valid or watchdog expiry; cache_vld=0.
REQ-015 flush in FIX or RESP: drop response, IDLE next cycle; flush in IDLE blocks accept that cycle.
REQ-016 mul_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-017 rst SHALL force IDLE, cache_vld=0, watchdog=0, and all outputs 0 except req_ready=1, asynchronously, including mid-operation.
REQ-018 First rising edge after rst deasserts SHALL be able to accept a request.

Verification
REQ-019 MUL 7 x 0xFFFFFFFD -> rsp_data 0xFFFFFFEB, rsp_err 0, tag echoed.
REQ-020 MULH 0x80000000 x 0x80000000 -> 0x40000000; then MUL same operands -> 0x00000000 at accept+2, no mul_start.
REQ-021 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE (cache miss both).
REQ-022 rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready 0; release -> IDLE next cycle.
REQ-023 flush in WAIT -> no rsp_valid; req_ready returns after mul_valid; repeat op re-launches mul_start.
REQ-024 mul_valid never driven -> rsp_err 1, rsp_data 0 at WDOG_LIMIT; funct3=100 -> rsp_err 1 at accept+1.
